// File: rtl/spi_baud_gen_master.sv
// spi_baud_gen_master
// Master-side SPI transfer timer. A transfer request starts a window of
// exactly BITS SCK periods; during that window M_BaudRate toggles every
// (spr+1) clk cycles and idle is low. At the end of the window the block
// returns to idle and pulses done for one cycle.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous active-high reset, highest priority
//   start      - transfer request, only looked at while idle
//   abort      - cancels the running transfer at the next edge, no done
//   spr        - half-period select, latched at start
//   M_BaudRate - baud square wave, held low whenever idle
//   idle       - 1 when no transfer is running
//   done       - one-cycle pulse after a transfer completes normally
//   bit_cnt    - SCK periods completed in the current or last transfer
module spi_baud_gen_master #(
    parameter int DIV_W = 8,
    parameter int BITS  = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] spr,
    output logic             M_BaudRate,
    output logic             idle,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    // half_cnt has to reach 2*BITS-1, which needs one more bit than bit_cnt.
    localparam int HALF_W = CNT_W + 1;
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * BITS - 1);
    localparam logic [CNT_W-1:0]  BITS_VAL  = CNT_W'(BITS);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
    logic [DIV_W-1:0]    spr_q, spr_d;
    logic                baud_q, baud_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            half_cnt_q <= '0;
            spr_q      <= '0;
            baud_q     <= 1'b0;
            done_q     <= 1'b0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            half_cnt_q <= half_cnt_d;
            spr_q      <= spr_d;
            baud_q     <= baud_d;
            done_q     <= done_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        half_cnt_d = half_cnt_q;
        spr_d      = spr_q;
        baud_d     = baud_q;
        done_d     = 1'b0;
        bit_cnt_d  = bit_cnt_q;

        case (state_q)
            IDLE: begin
                // abort alongside start keeps the block idle.
                if (start && !abort) begin
                    state_d    = RUN;
                    baud_d     = 1'b0;
                    div_cnt_d  = '0;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    spr_d      = spr;
                end
            end

            RUN: begin
                // abort outranks a coinciding toggle or completion, and the
                // period count is frozen at what was already shown.
                if (abort) begin
                    state_d = IDLE;
                    baud_d  = 1'b0;
                end else if (div_cnt_q == spr_q) begin
                    div_cnt_d  = '0;
                    baud_d     = ~baud_q;
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                    // A 1->0 toggle closes one full SCK period.
                    if (baud_q) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (half_cnt_q == LAST_HALF) begin
                        state_d   = IDLE;
                        baud_d    = 1'b0;
                        done_d    = 1'b1;
                        bit_cnt_d = BITS_VAL;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign M_BaudRate = baud_q;
    assign idle       = (state_q == IDLE);
    assign done       = done_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_spi_baud_gen_master.sv
// tb_spi_baud_gen_master
// Bench for spi_baud_gen_master. A reference model tracks where the running
// transfer is as a plain cycle index and derives the expected outputs from it
// with arithmetic; a compare process checks every cycle against that model.
// Directed scenarios add hand-computed expectations, then random traffic runs.
module tb_spi_baud_gen_master;

    localparam int DIV_W = 8;
    localparam int BITS  = 8;
    localparam int CNT_W = 4;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [DIV_W-1:0] spr   = '0;
    logic             M_BaudRate;
    logic             idle;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    spi_baud_gen_master #(
        .DIV_W(DIV_W),
        .BITS (BITS),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .spr       (spr),
        .M_BaudRate(M_BaudRate),
        .idle      (idle),
        .done      (done),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // Model state: m_t is the index of the current run cycle (0 = first),
    // m_s the latched half-period select, m_bits the count held while idle.
    bit m_on   = 1'b0;
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_t    = 0;
    int m_s    = 0;
    int m_bits = 0;

    function automatic int expBaud();
        return m_run ? ((m_t / (m_s + 1)) % 2) : 0;
    endfunction

    function automatic int expBit();
        return m_run ? (m_t / (2 * (m_s + 1))) : m_bits;
    endfunction

    // Advance the model by one clock using the inputs the DUT sees.
    always @(posedge clk) begin
        if (rst) begin
            m_on   = 1'b1;
            m_run  = 1'b0;
            m_done = 1'b0;
            m_bits = 0;
            m_t    = 0;
            m_s    = 0;
        end else if (m_run) begin
            m_done = 1'b0;
            if (abort) begin
                m_bits = expBit();
                m_run  = 1'b0;
            end else if (m_t == 2 * BITS * (m_s + 1) - 1) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_bits = BITS;
            end else begin
                m_t++;
            end
        end else begin
            m_done = 1'b0;
            if (start && !abort) begin
                m_run = 1'b1;
                m_t   = 0;
                m_s   = int'(spr);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_on) begin
            checkOutput("model_idle", int'(idle), int'(!m_run));
            checkOutput("model_baud", int'(M_BaudRate), expBaud());
            checkOutput("model_done", int'(done), int'(m_done));
            checkOutput("model_bit_cnt", int'(bit_cnt), expBit());
        end
    end

    // Drive one cycle of inputs, returning at the next falling edge.
    task automatic applyStimulus(input bit r, input bit s, input bit a, input int sp);
        rst   = r;
        start = s;
        abort = a;
        spr   = DIV_W'(sp);
        @(negedge clk);
    endtask

    // Called on run cycle 1 (start already accepted). Counts run cycles and
    // cycles with M_BaudRate high; pulses start/abort/rst at given cycles.
    task automatic measureRun(input int sp_run, input int start_at, input int abort_at,
                              input int rst_at, input int bound,
                              output int len, output int hi);
        len = 0;
        hi  = 0;
        while (idle == 1'b0 && len < bound) begin
            len++;
            hi += int'(M_BaudRate);
            applyStimulus(len == rst_at, len == start_at, len == abort_at, sp_run);
        end
    endtask

    int len;
    int hi;

    initial begin
        // Reset state.
        repeat (3) applyStimulus(1, 0, 0, 0);
        checkOutput("reset_idle", int'(idle), 1);
        checkOutput("reset_baud", int'(M_BaudRate), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_bit_cnt", int'(bit_cnt), 0);
        applyStimulus(0, 0, 0, 0);

        // spr=0: 16 run cycles, half of them high, done on cycle 17.
        applyStimulus(0, 1, 0, 0);
        checkOutput("spr0_first_baud", int'(M_BaudRate), 0);
        measureRun(0, 0, 0, 0, 100, len, hi);
        checkOutput("spr0_len", len, 16);
        checkOutput("spr0_hi", hi, 8);
        checkOutput("spr0_done", int'(done), 1);
        checkOutput("spr0_bit_cnt", int'(bit_cnt), 8);
        applyStimulus(0, 0, 0, 0);
        checkOutput("spr0_done_clears", int'(done), 0);
        checkOutput("spr0_bit_cnt_hold", int'(bit_cnt), 8);

        // spr=3: 4 cycles per level, 64 run cycles.
        applyStimulus(0, 1, 0, 3);
        measureRun(3, 0, 0, 0, 200, len, hi);
        checkOutput("spr3_len", len, 64);
        checkOutput("spr3_hi", hi, 32);
        checkOutput("spr3_bit_cnt", int'(bit_cnt), 8);

        // spr changed to 0 mid-run must not alter timing.
        applyStimulus(0, 1, 0, 3);
        measureRun(0, 0, 0, 0, 200, len, hi);
        checkOutput("spr_change_len", len, 64);
        checkOutput("spr_change_done", int'(done), 1);

        // start during RUN is ignored; start in the done cycle is accepted.
        applyStimulus(0, 1, 0, 0);
        measureRun(0, 10, 0, 0, 100, len, hi);
        checkOutput("restart_ignored_len", len, 16);
        checkOutput("restart_ignored_done", int'(done), 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("done_cycle_start_idle", int'(idle), 0);
        checkOutput("done_cycle_start_bit_cnt", int'(bit_cnt), 0);
        measureRun(0, 0, 0, 0, 100, len, hi);
        checkOutput("done_cycle_start_len", len, 16);

        // abort at cycle 5.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        measureRun(0, 0, 5, 0, 100, len, hi);
        checkOutput("abort_len", len, 5);
        checkOutput("abort_baud", int'(M_BaudRate), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_bit_cnt", int'(bit_cnt), 2);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort_idle_no_effect", int'(bit_cnt), 2);

        // abort together with start in IDLE stays idle.
        applyStimulus(0, 1, 1, 0);
        checkOutput("start_abort_idle", int'(idle), 1);

        // rst at cycle 7 of a spr=1 run, then a full run.
        applyStimulus(0, 1, 0, 1);
        measureRun(1, 0, 0, 7, 100, len, hi);
        checkOutput("rst_len", len, 7);
        checkOutput("rst_bit_cnt", int'(bit_cnt), 0);
        checkOutput("rst_done", int'(done), 0);
        applyStimulus(0, 1, 0, 1);
        measureRun(1, 0, 0, 0, 100, len, hi);
        checkOutput("after_rst_len", len, 32);
        checkOutput("after_rst_bit_cnt", int'(bit_cnt), 8);

        // Largest divisor: 256 cycles per level.
        applyStimulus(0, 1, 0, 255);
        measureRun(255, 0, 0, 0, 5000, len, hi);
        checkOutput("spr_max_len", len, 4096);
        checkOutput("spr_max_hi", hi, 2048);
        checkOutput("spr_max_done", int'(done), 1);

        // Random traffic checked only by the model.
        for (int i = 0; i < 20000; i++) begin
            applyStimulus($urandom_range(0, 999) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 63) == 0,
                          ($urandom_range(0, 99) == 0) ? 255 : int'($urandom_range(0, 5)));
        end
        applyStimulus(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/spi_baud_gen_master.md
Name: spi_baud_gen_master

Overview:
- Master-side SPI transfer timer.
- Generates the baud-rate square wave M_BaudRate and the transfer-window flag idle that drive the downstream SCK control stage.
- From a start request, times exactly BITS SCK periods at a programmable rate, then returns to idle and reports completion.
- Sits between the SPI master control/register block and the SCK control stage.

Parameters:
- DIV_W, 8, width of the half-period divisor input spr.
- BITS, 8, SCK periods per transfer; legal range 1..(2**CNT_W - 1).
- CNT_W, 4, width of the bit_cnt output.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  transfer request; sampled only while idle=1.
- abort  input  1  synchronous cancel of the current transfer.
- spr  input  DIV_W  half-period select; each M_BaudRate level lasts (spr+1) clk cycles.
- M_BaudRate  output  1  baud square wave; 0 whenever idle.
- idle  output  1  1 = no transfer active.
- done  output  1  one-cycle pulse on normal completion.
- bit_cnt  output  CNT_W  completed SCK periods in the current or last transfer.

Behaviour:
- Reset values (rst=1 at an edge): M_BaudRate=0, idle=1, done=0, bit_cnt=0, internal div_cnt=0, half_cnt=0, spr_q=0. rst has priority over all other inputs.
- States: IDLE (idle=1) and RUN (idle=0). No other states.
- IDLE -> RUN: start=1 and abort=0 at an edge. On that edge:
  - idle<=0, M_BaudRate<=0, div_cnt<=0, half_cnt<=0, bit_cnt<=0, spr_q<=spr.
  - The first RUN cycle shows M_BaudRate=0.
- spr is latched at start only. Changes to spr during RUN have no effect.
- RUN, each edge:
  - If div_cnt==spr_q: div_cnt<=0, M_BaudRate<=~M_BaudRate, half_cnt<=half_cnt+1.
  - Otherwise: div_cnt<=div_cnt+1.
- bit_cnt increments on each 1->0 toggle of M_BaudRate, including the final one.
- Completion: when a toggle occurs with half_cnt==2*BITS-1:
  - idle<=1, M_BaudRate<=0, done<=1 for exactly one cycle, bit_cnt<=BITS.
  - RUN lasts exactly 2*BITS*(spr+1) cycles.
- bit_cnt holds its final value in IDLE until the next accepted start.
- spr=0 boundary: M_BaudRate toggles every clk cycle (clk/2).
- Maximum spr (all ones): 2**DIV_W cycles per level. Counters must not overflow.
- start while RUN: ignored. No queuing.
- start in the cycle done=1: accepted, since idle=1 that cycle.
- abort in RUN: at the next edge idle<=1, M_BaudRate<=0, done stays 0. bit_cnt holds the completed count.
- abort in IDLE: no effect. abort=1 together with start=1 in IDLE: stays IDLE.
- abort on the same edge as completion: abort wins, no done pulse.
- rst mid-transfer: all outputs return to reset values at that edge. No done pulse.
- done is registered and never asserted while idle=0.

Test Plan:
- Reset, then start=1 for 1 cycle with spr=0, BITS=8:
  - idle=0 for exactly 16 cycles; M_BaudRate reads 0,1,0,1,...,1.
  - done=1 in the 17th cycle after start with idle=1; bit_cnt=8.
- spr=3: each M_BaudRate level lasts 4 cycles; idle=0 for 64 cycles; bit_cnt steps 1..8 on each falling toggle.
- spr=3 at start, then change spr to 0 during RUN: timing stays 4 cycles/level and 64 cycles total.
- start pulsed again at cycle 10 of a spr=0 transfer: no effect; single done at cycle 17. Then start in the done cycle: a new 16-cycle transfer begins and bit_cnt clears to 0.
- abort at cycle 5 of a spr=0 transfer: idle=1 and M_BaudRate=0 next cycle; done never pulses; bit_cnt=2.
- rst=1 at cycle 7 of a spr=1 transfer: next cycle M_BaudRate=0, idle=1, done=0, bit_cnt=0. A subsequent start runs a full 32-cycle transfer.
